mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: shares one memory port between icache fills and dcache fills/writebacks.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin on contention; default is dcache priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp,
  output logic [1:0]        owner
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  state_t     r_state;
  logic [1:0] r_last_owner;
  logic       w_d_pend;
  logic       w_sel_d;

  // dcache wins unless round-robin is enabled and it was the last one served
  assign w_d_pend = d_read | d_write;
  assign w_sel_d  = w_d_pend & (~i_read | ~RR_EN | (r_last_owner != OWN_D));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_owner <= OWN_I;
      owner        <= OWN_NONE;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          // m_read/m_write act as the latched op; read+write together is a write
          if (w_sel_d) begin
            r_state      <= SERVE_D;
            owner        <= OWN_D;
            r_last_owner <= OWN_D;
            m_addr       <= d_addr;
            m_wdata      <= d_wdata;
            m_write      <= d_write;
            m_read       <= ~d_write;
          end else if (i_read) begin
            r_state      <= SERVE_I;
            owner        <= OWN_I;
            r_last_owner <= OWN_I;
            m_addr       <= i_addr;
            m_wdata      <= '0;
            m_write      <= 1'b0;
            m_read       <= 1'b1;
          end
        end
        SERVE_I: begin
          if (m_resp) begin
            i_rdata <= m_rdata;
            i_resp  <= 1'b1;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            r_state <= RESP;
          end
        end
        SERVE_D: begin
          if (m_resp) begin
            d_rdata <= m_rdata;
            d_resp  <= 1'b1;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            r_state <= RESP;
          end
        end
        RESP: begin
          owner   <= OWN_NONE;
          r_state <= RELEASE;
        end
        RELEASE: begin
          r_state <= IDLE;
        end
        default: begin
          owner   <= OWN_NONE;
          m_read  <= 1'b0;
          m_write <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
